// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - issue-stage load scoreboard with RAW/WAW stall and one output register
//
// Purpose: accepts decoded instructions over a valid/ready handshake. It records
// the destination register of each outstanding load and stalls any instruction
// that reads such a register, or that is a load writing one. Loads also stall
// once MAX_LOADS are in flight. An accepted instruction is forwarded through a
// single output register.
//
// Optional feature: define ISSUE_STALL_CNT_EN to enable the saturating stall_cnt counter.
// When the macro is undefined, stall_cnt is tied to 0 and no counter flops are built.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   flush                       drop the held output instruction; blocks accept this cycle
//   in_valid / in_ready         decoder handshake
//   in_instr, in_rs1/2/rd(+_valid), in_is_load   decoded fields
//   out_valid / out_ready       execute-stage handshake
//   out_instr, out_rs1/2/rd     registered copies of the accepted fields
//   wb_valid, wb_rd             load writeback that clears a scoreboard bit
//   pending                     scoreboard, bit n = load to xn outstanding
//   stall_cnt                   hazard stall-cycle counter (optional)
module issue_scoreboard #(
  parameter int MAX_LOADS = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [4:0]       in_rs1,
  input  logic             in_rs1_valid,
  input  logic [4:0]       in_rs2,
  input  logic             in_rs2_valid,
  input  logic [4:0]       in_rd,
  input  logic             in_rd_valid,
  input  logic             in_is_load,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] LOAD_LIMIT = 4'(MAX_LOADS);

  logic [3:0]  load_cnt;
  logic        hazard;
  logic        accept;
  logic        set_en;
  logic        clr_en;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  // The hazard term uses only registered scoreboard state. A writeback in this
  // cycle therefore releases a stalled instruction one cycle later; there is no
  // same-cycle bypass.
  always_comb begin
    hazard = 1'b0;
    if (in_rs1_valid && in_rs1 != 5'd0 && pending[in_rs1]) hazard = 1'b1;
    if (in_rs2_valid && in_rs2 != 5'd0 && pending[in_rs2]) hazard = 1'b1;
    if (in_is_load && in_rd_valid && in_rd != 5'd0 && pending[in_rd]) hazard = 1'b1;
    if (in_is_load && load_cnt == LOAD_LIMIT) hazard = 1'b1;
  end

  assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush;
  assign accept   = in_valid & in_ready;

  // The WAW check means an accepted load always targets a clear bit. A
  // writeback only clears a set bit. Set and clear can therefore never hit the
  // same register in one cycle.
  assign set_en = accept & in_is_load & in_rd_valid & (in_rd != 5'd0);
  assign clr_en = wb_valid & (wb_rd != 5'd0) & pending[wb_rd];

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en) set_vec[in_rd] = 1'b1;
    if (clr_en) clr_vec[wb_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      load_cnt  <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
      out_rd    <= '0;
    end else begin
      pending <= ((pending | set_vec) & ~clr_vec) & ~32'd1;
      if (set_en && !clr_en)
        load_cnt <= load_cnt + 4'd1;
      else if (clr_en && !set_en)
        load_cnt <= load_cnt - 4'd1;

      // Output fields change only on accept, so they hold while stalled downstream.
      if (accept) begin
        out_valid <= 1'b1;
        out_instr <= in_instr;
        out_rs1   <= in_rs1;
        out_rs2   <= in_rs2;
        out_rd    <= in_rd;
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (in_valid && hazard && !flush && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed self-checking bench for issue_scoreboard
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  in_rs1;
  logic        in_rs1_valid;
  logic [4:0]  in_rs2;
  logic        in_rs2_valid;
  logic [4:0]  in_rd;
  logic        in_rd_valid;
  logic        in_is_load;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] pending;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  issue_scoreboard #(.MAX_LOADS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1(in_rs1), .in_rs1_valid(in_rs1_valid),
    .in_rs2(in_rs2), .in_rs2_valid(in_rs2_valid),
    .in_rd(in_rd), .in_rd_valid(in_rd_valid), .in_is_load(in_is_load),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .pending(pending), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [4:0] rs1, input logic rs1v,
                       input logic [4:0] rs2, input logic rs2v, input logic [4:0] rd,
                       input logic rdv, input logic ld);
    in_valid     = 1'b1;
    in_instr     = instr;
    in_rs1       = rs1;
    in_rs1_valid = rs1v;
    in_rs2       = rs2;
    in_rs2_valid = rs2v;
    in_rd        = rd;
    in_rd_valid  = rdv;
    in_is_load   = ld;
    #1;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    #1;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid = 1'b1;
    wb_rd    = rd;
    tick();
    wb_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0;
    in_valid = 1'b0; in_instr = '0; in_rs1 = '0; in_rs1_valid = 1'b0;
    in_rs2 = '0; in_rs2_valid = 1'b0; in_rd = '0; in_rd_valid = 1'b0; in_is_load = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // 1: ADD x3,x1,x2
    drive(32'h002081b3, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    tick();
    idle();
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_rd", 32'(out_rd), 32'd3);
    chk("t1_out_rs1", 32'(out_rs1), 32'd1);
    chk("t1_out_rs2", 32'(out_rs2), 32'd2);
    chk("t1_out_instr", out_instr, 32'h002081b3);
    chk("t1_pending", pending, 32'd0);
    tick();
    chk("t1_drained", 32'(out_valid), 32'd0);
    chk("t1_hold_rd", 32'(out_rd), 32'd3);

    // 2: LW x5, then ADD x6,x5,x1 must wait for wb to x5
    drive(32'h00002283, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    chk("t2_lw_ready", 32'(in_ready), 32'd1);
    tick();
    chk("t2_pending_set", pending, 32'h0000_0020);
    drive(32'h00128333, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    chk("t2_raw_stall", 32'(in_ready), 32'd0);
    tick();
    chk("t2_raw_stall2", 32'(in_ready), 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd5; #1;
    chk("t2_no_bypass", 32'(in_ready), 32'd0);
    tick();
    wb_valid = 1'b0; #1;
    chk("t2_pending_clr", pending, 32'd0);
    chk("t2_released", 32'(in_ready), 32'd1);
    tick();
    idle();
    chk("t2_out_rd", 32'(out_rd), 32'd6);
    chk("t2_out_valid", 32'(out_valid), 32'd1);

    // 3: four loads fill the limit, fifth waits for a writeback
    for (int i = 1; i <= 4; i++) begin
      drive(32'h00002003 | (32'(i) << 7), 5'd0, 1'b1, 5'd0, 1'b0, 5'(i), 1'b1, 1'b1);
      tick();
    end
    chk("t3_pending4", pending, 32'h0000_001e);
    drive(32'h00002303, 5'd0, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    chk("t3_full_stall", 32'(in_ready), 32'd0);
    tick();
    chk("t3_full_stall2", 32'(in_ready), 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd2; #1;
    chk("t3_wb_no_bypass", 32'(in_ready), 32'd0);
    tick();
    wb_valid = 1'b0; #1;
    chk("t3_pending_wb", pending, 32'h0000_001a);
    chk("t3_fifth_ready", 32'(in_ready), 32'd1);
    tick();
    chk("t3_pending5", pending, 32'h0000_005a);
    chk("t3_out_rd", 32'(out_rd), 32'd6);
    drive(32'h00002383, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    chk("t3_cnt4_stall", 32'(in_ready), 32'd0);
    drive(32'h000003b3, 5'd9, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    chk("t3_nonload_ok", 32'(in_ready), 32'd1);
    drive(32'h00002083, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1);
    chk("t3_waw_stall", 32'(in_ready), 32'd0);
    idle();
    wb(5'd1); wb(5'd3); wb(5'd4); wb(5'd6);
    chk("t3_all_clear", pending, 32'd0);

    // 4: downstream back-pressure holds the output register
    out_ready = 1'b0;
    drive(32'hAAAA_0001, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    chk("t4_out_a", out_instr, 32'hAAAA_0001);
    drive(32'hBBBB_0002, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    chk("t4_blocked", 32'(in_ready), 32'd0);
    tick();
    chk("t4_hold_instr", out_instr, 32'hAAAA_0001);
    chk("t4_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1; #1;
    chk("t4_unblocked", 32'(in_ready), 32'd1);
    tick();
    idle();
    chk("t4_out_b", out_instr, 32'hBBBB_0002);
    tick();

    // 5: x0 is never tracked; stray writeback ignored
    drive(32'h00002003, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    chk("t5_x0_pending", pending, 32'd0);
    drive(32'h00000533, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0);
    chk("t5_x0_ready", 32'(in_ready), 32'd1);
    tick();
    idle();
    wb(5'd9);
    chk("t5_stray_wb", pending, 32'd0);

    // reset in the middle of an accepted load
    drive(32'h00002603, 5'd0, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("rst2_pending", pending, 32'd0);
    chk("rst2_out_valid", 32'(out_valid), 32'd0);

    // 6: flush kills output but keeps the scoreboard; then 3 hazard cycles
    out_ready = 1'b0;
    drive(32'h00002403, 5'd0, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    chk("t6_out_valid", 32'(out_valid), 32'd1);
    chk("t6_pending", pending, 32'h0000_0100);
    drive(32'h000404b3, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    flush = 1'b1; #1;
    chk("t6_flush_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; #1;
    chk("t6_flushed", 32'(out_valid), 32'd0);
    chk("t6_pending_kept", pending, 32'h0000_0100);
    chk("t6_stall_cnt0", 32'(stall_cnt), 32'd0);
    repeat (3) tick();
    idle();
`ifdef ISSUE_STALL_CNT_EN
    chk("t6_stall_cnt3", 32'(stall_cnt), 32'd3);
`else
    chk("t6_stall_cnt_off", 32'(stall_cnt), 32'd0);
`endif
    wb(5'd8);
    chk("t6_pending_clr", pending, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
